// File: rtl/fpga_cfg_sequencer_pkg.sv
// rtl/fpga_cfg_sequencer_pkg.sv - shared definitions for the configuration sequencer
// Holds register offsets, CTRL/STATUS bit positions, the column-select width
// and the sequencer FSM state encoding. It has no ports.
package fpga_cfg_sequencer_pkg;

  // Register offsets, taken from wbs_addr_i[3:2]
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DATA   = 2'd2;
  localparam logic [1:0] OFF_LEN    = 2'd3;

  // CTRL bit positions
  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_COL_LSB = 8;

  // STATUS bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_LEN_ERR = 3;
  localparam int STAT_LVL_LSB = 4;

  localparam int CONFIG_COL_WIDTH = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SHIFT = 3'd2,
    ST_SET   = 3'd3,
    ST_DONE  = 3'd4
  } cfg_state_t;

endpackage

// File: rtl/fpga_cfg_sequencer_cfg_fifo.sv
// rtl/fpga_cfg_sequencer_cfg_fifo.sv - synchronous config-word FIFO
// Ports: clk/rst_n (async active-low reset), push/wdata (dropped when full),
// pop (ignored when empty), flush (empties the FIFO, wins over push/pop),
// rdata (head word, valid while !empty), full, empty, level (entries held).
module cfg_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LW-1:0]    wptr;
  logic [LW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so level covers 0..DEPTH.
  assign level   = wptr - rptr;
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + LW'(1);
      if (do_pop)  rptr <= rptr + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fpga_cfg_sequencer.sv
// rtl/fpga_cfg_sequencer.sv - Wishbone-driven serial configuration sequencer
// Ports: wb_clk_i/wb_rst_ni (async active-low reset); Wishbone slave
// wbs_stb_i/wbs_cyc_i/wbs_we_i/wbs_sel_i/wbs_addr_i/wbs_data_i in,
// wbs_ack_o/wbs_data_o out (data is 0 outside ack so regions can be OR-ed);
// config lines cen_o (region enable), shift_o/data_o/set_o (per column).
module fpga_cfg_sequencer
  import fpga_cfg_sequencer_pkg::*;
#(
  parameter int          NUM_COLS   = 4,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          LEN_W      = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_data_i,
  input  logic [31:0]         wbs_addr_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_data_o,
  output logic                cen_o,
  output logic [NUM_COLS-1:0] shift_o,
  output logic [NUM_COLS-1:0] data_o,
  output logic [NUM_COLS-1:0] set_o
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  cfg_state_t state_q, state_d;

  logic                        hit;
  logic                        ack_q;
  logic [1:0]                  offset;
  logic                        wr;
  logic                        wr_ctrl, wr_status, wr_data, wr_len;
  logic                        start_req, abort_req, start_ok, run_abort;
  logic [CONFIG_COL_WIDTH-1:0] col_q, run_col;
  logic [LEN_W-1:0]            len_q, remain_q;
  logic [31:0]                 sr_q;
  logic [5:0]                  bitcnt_q;
  logic                        done_q, ovf_q, len_err_q;
  logic                        fifo_pop, fifo_full, fifo_empty;
  logic [31:0]                 fifo_rdata;
  logic [LVL_W-1:0]            fifo_level;
  logic [NUM_COLS-1:0]         col_onehot;
  logic [31:0]                 status_word;
  logic [31:0]                 rdata;
  logic                        unused_ok;

  // Byte lanes and the low address bits are not decoded: full-word access only.
  assign unused_ok = &{1'b0, wbs_sel_i, wbs_addr_i[1:0]};

  // Bus decode. The ack toggles off after one cycle so a held strobe never
  // sees two consecutive acks; register side effects land on the ack cycle.
  assign hit    = wbs_stb_i & wbs_cyc_i & (wbs_addr_i[31:4] == BASE_ADDR[31:4]);
  assign offset = wbs_addr_i[3:2];

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) ack_q <= 1'b0;
    else            ack_q <= hit & ~ack_q;
  end

  assign wbs_ack_o = ack_q;
  assign wr        = ack_q & hit & wbs_we_i;
  assign wr_ctrl   = wr & (offset == OFF_CTRL);
  assign wr_status = wr & (offset == OFF_STATUS);
  assign wr_data   = wr & (offset == OFF_DATA);
  assign wr_len    = wr & (offset == OFF_LEN);

  // Abort in the same word masks start.
  assign start_req = wr_ctrl & wbs_data_i[CTRL_START] & ~wbs_data_i[CTRL_ABORT];
  assign abort_req = wr_ctrl & wbs_data_i[CTRL_ABORT];
  assign run_abort = abort_req & (state_q != ST_IDLE);

  cfg_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .push  (wr_data),
    .pop   (fifo_pop),
    .flush (run_abort),
    .wdata (wbs_data_i),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign col_onehot = NUM_COLS'(1) << run_col;
  assign cen_o      = (state_q != ST_IDLE);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    fifo_pop = 1'b0;
    shift_o  = '0;
    data_o   = '0;
    set_o    = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_req && (len_q != '0)) begin
          start_ok = 1'b1;
          state_d  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_o = col_onehot;
        if (sr_q[0]) data_o = col_onehot;
        if (bitcnt_q == 6'd1) begin
          state_d = (remain_q == LEN_W'(1)) ? ST_SET : ST_FETCH;
        end
      end
      ST_SET: begin
        set_o   = col_onehot;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (run_abort) begin
      state_d  = ST_IDLE;
      fifo_pop = 1'b0;
    end
  end

  // Datapath. The column of a run comes from the written word itself so that a
  // start carrying a new column uses it immediately.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      col_q    <= '0;
      len_q    <= '0;
      run_col  <= '0;
      remain_q <= '0;
      sr_q     <= '0;
      bitcnt_q <= '0;
    end else begin
      if (wr_ctrl) col_q <= wbs_data_i[CTRL_COL_LSB +: CONFIG_COL_WIDTH];
      if (wr_len)  len_q <= wbs_data_i[LEN_W-1:0];
      if (start_ok) begin
        run_col  <= wbs_data_i[CTRL_COL_LSB +: CONFIG_COL_WIDTH];
        remain_q <= len_q;
      end else if (fifo_pop) begin
        sr_q     <= fifo_rdata;
        bitcnt_q <= (remain_q >= LEN_W'(32)) ? 6'd32 : remain_q[5:0];
      end else if (state_q == ST_SHIFT) begin
        sr_q     <= sr_q >> 1;
        bitcnt_q <= bitcnt_q - 6'd1;
        remain_q <= remain_q - LEN_W'(1);
      end
    end
  end

  // Sticky flags: write-1-to-clear first, hardware events override.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      if (wr_status) begin
        if (wbs_data_i[STAT_DONE])    done_q    <= 1'b0;
        if (wbs_data_i[STAT_OVF])     ovf_q     <= 1'b0;
        if (wbs_data_i[STAT_LEN_ERR]) len_err_q <= 1'b0;
      end
      if (wr_data && fifo_full) ovf_q <= 1'b1;
      if (start_req && (state_q == ST_IDLE) && (len_q == '0)) len_err_q <= 1'b1;
      if (start_ok) done_q <= 1'b0;
      if ((state_q == ST_DONE) && !run_abort) done_q <= 1'b1;
    end
  end

  always_comb begin
    status_word                         = '0;
    status_word[STAT_BUSY]              = (state_q != ST_IDLE);
    status_word[STAT_DONE]              = done_q;
    status_word[STAT_OVF]               = ovf_q;
    status_word[STAT_LEN_ERR]           = len_err_q;
    status_word[STAT_LVL_LSB +: 4]      = 4'(fifo_level);
  end

  always_comb begin
    rdata = '0;
    case (offset)
      OFF_CTRL:   rdata[CTRL_COL_LSB +: CONFIG_COL_WIDTH] = col_q;
      OFF_STATUS: rdata = status_word;
      OFF_LEN:    rdata[LEN_W-1:0] = len_q;
      default:    rdata = '0;
    endcase
  end

  assign wbs_data_o = ack_q ? rdata : '0;

endmodule

// File: tb/tb_fpga_cfg_sequencer.sv
// tb/tb_fpga_cfg_sequencer.sv - self-checking bench for fpga_cfg_sequencer
module tb_fpga_cfg_sequencer;

  localparam logic [31:0] BASE     = 32'h3000_0000;
  localparam logic [31:0] A_CTRL   = BASE + 32'h0;
  localparam logic [31:0] A_STATUS = BASE + 32'h4;
  localparam logic [31:0] A_DATA   = BASE + 32'h8;
  localparam logic [31:0] A_LEN    = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] wdat, addr, rdat;
  logic        ack, cen;
  logic [3:0]  shift, data, set;

  fpga_cfg_sequencer dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .wbs_stb_i  (stb),
    .wbs_cyc_i  (cyc),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_data_i (wdat),
    .wbs_addr_i (addr),
    .wbs_ack_o  (ack),
    .wbs_data_o (rdat),
    .cen_o      (cen),
    .shift_o    (shift),
    .data_o     (data),
    .set_o      (set)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;

  // Model: word queue, run parameters and sticky flags
  logic [31:0] mq [$];
  int          m_len = 0, m_rem = 0, m_col = 0, m_bits = 0, m_tail = 0;
  logic [31:0] m_word = '0;
  logic [3:0]  m_oh;
  bit          m_run = 0, m_done = 0, m_ovf = 0, m_lenerr = 0;
  int          beats = 0, sets = 0, first_beat_cyc = -1, start_cyc = 0;
  logic [63:0] beat_log = '0;
  logic [3:0]  last_shift = '0, last_set = '0;
  logic [31:0] words [5] = '{32'h1234_5678, 32'hDEAD_BEEF, 32'h0F0F_00FF,
                             32'h8000_0001, 32'hAAAA_AAAA};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mstatus();
    return {24'b0, 4'(mq.size()), m_lenerr, m_ovf, m_done, m_run};
  endfunction

  task automatic model_reset();
    m_run = 0; m_done = 0; m_ovf = 0; m_lenerr = 0;
    m_len = 0; m_rem = 0; m_bits = 0; m_tail = 0;
    mq.delete();
  endtask

  task automatic model_write(input logic [1:0] off, input logic [31:0] d);
    case (off)
      2'd0: begin
        if (d[1]) begin
          if (m_run) begin
            m_run = 0; m_bits = 0; m_tail = 0;
            mq.delete();
          end
        end else if (d[0] && !m_run) begin
          if (m_len == 0) m_lenerr = 1;
          else begin
            m_run = 1; m_rem = m_len; m_col = int'(d[9:8]); m_bits = 0;
            m_done = 0; beats = 0; first_beat_cyc = -1; beat_log = '0;
            start_cyc = cyc_cnt;
          end
        end
      end
      2'd1: begin
        if (d[1]) m_done = 0;
        if (d[2]) m_ovf = 0;
        if (d[3]) m_lenerr = 0;
      end
      2'd2: begin
        if (mq.size() < 4) mq.push_back(d);
        else m_ovf = 1;
      end
      default: m_len = int'(d[15:0]);
    endcase
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    bit got = 0;
    @(negedge clk);
    stb = 1; cyc = 1; we = 1; addr = a; wdat = d;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (ack) got = 1;
    end
    chk("wr_ack_seen", 32'(got), 32'd1);
    if (got) model_write(a[3:2], d);
    @(negedge clk);
    chk("wr_ack_single", 32'(ack), 32'd0);
    stb = 0; cyc = 0; we = 0;
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    bit got = 0;
    d = '0;
    @(negedge clk);
    stb = 1; cyc = 1; we = 0; addr = a;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (ack) begin
        got = 1;
        d = rdat;
      end
    end
    chk("rd_ack_seen", 32'(got), 32'd1);
    @(negedge clk);
    chk("rd_ack_single", 32'(ack), 32'd0);
    stb = 0; cyc = 0;
  endtask

  task automatic wb_miss(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    stb = 1; cyc = 1; we = 1; addr = a; wdat = d;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("miss_ack", 32'(ack), 32'd0);
      chk("miss_rdata", rdat, 32'd0);
    end
    stb = 0; cyc = 0; we = 0;
  endtask

  task automatic wait_beats(input int n, input string name);
    int k = 0;
    while (beats < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(beats), 32'(n));
  endtask

  task automatic wait_sets(input int n, input string name);
    int k = 0;
    while (sets < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(sets), 32'(n));
  endtask

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  // Compare process: every cycle out of reset, sampled 2ns after the edge
  initial forever begin
    @(posedge clk);
    #2;
    if (rst_n) begin
      m_oh = 4'(1 << m_col);
      chk("cen", 32'(cen), 32'(m_run));
      chk("data_gated", 32'(data & ~shift), 32'd0);
      if (shift != 4'b0) begin
        chk("shift_col", 32'(shift), m_run ? 32'(m_oh) : 32'd0);
        if (m_run) begin
          chk("beat_in_range", 32'(m_rem > 0), 32'd1);
          if (m_bits == 0) begin
            chk("beat_has_data", 32'(mq.size() > 0), 32'd1);
            m_word = (mq.size() > 0) ? mq.pop_front() : 32'd0;
            m_bits = (m_rem >= 32) ? 32 : m_rem;
          end
          chk("data_bit", 32'((data & m_oh) != 4'b0), 32'(m_word[0]));
          if (beats < 64) beat_log[beats] = ((data & m_oh) != 4'b0);
          if (beats == 0) first_beat_cyc = cyc_cnt;
          last_shift = shift;
          beats++;
          m_word = m_word >> 1;
          m_bits--;
          m_rem--;
        end
      end
      if (set != 4'b0) begin
        chk("set_col", 32'(set), m_run ? 32'(m_oh) : 32'd0);
        chk("set_after_last_bit", 32'(m_rem), 32'd0);
        last_set = set;
        sets++;
        m_tail = 1;
      end else if (m_tail == 1) begin
        m_tail = 0;
        m_run = 0;
        m_done = 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int s0;
    stb = 0; cyc = 0; we = 0; sel = 4'hF; addr = '0; wdat = '0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", 32'({ack, cen, shift, data, set}), 32'd0);
    chk("rst_rdata", rdat, 32'd0);
    rst_n = 1;
    wb_read(A_STATUS, r); chk("rst_status", r, 32'd0);
    wb_read(A_LEN, r);    chk("rst_len", r, 32'd0);
    wb_read(A_CTRL, r);   chk("rst_ctrl", r, 32'd0);

    // LEN=8, column 2, one word
    wb_write(A_LEN, 32'd8);
    wb_write(A_DATA, 32'h0000_00A5);
    wb_write(A_CTRL, 32'h0000_0201);
    wait_sets(1, "t1_set_seen");
    chk("t1_latency", 32'(first_beat_cyc - start_cyc), 32'd2);
    chk("t1_beats", 32'(beats), 32'd8);
    chk("t1_bits", 32'(beat_log[7:0]), 32'h0000_00A5);
    chk("t1_shift", 32'(last_shift), 32'h4);
    chk("t1_set", 32'(last_set), 32'h4);
    repeat (3) @(negedge clk);
    wb_read(A_STATUS, r);
    chk("t1_status", r, mstatus());
    chk("t1_status_lit", r, 32'h0000_0002);
    wb_read(A_CTRL, r); chk("t1_ctrl_col", r, 32'h0000_0200);

    // LEN=40 with only one word: stall in fetch until the second arrives
    wb_write(A_LEN, 32'd40);
    wb_write(A_DATA, 32'hFFFF_FFFF);
    wb_write(A_CTRL, 32'h0000_0101);
    wait_beats(32, "t2_first_word");
    repeat (6) @(negedge clk);
    chk("t2_stall_beats", 32'(beats), 32'd32);
    chk("t2_stall_cen", 32'(cen), 32'd1);
    chk("t2_stall_shift", 32'(shift), 32'd0);
    wb_write(A_DATA, 32'h0000_0000);
    wait_sets(2, "t2_set_seen");
    chk("t2_beats", 32'(beats), 32'd40);
    chk("t2_ones", beat_log[31:0], 32'hFFFF_FFFF);
    chk("t2_zeros", 32'(beat_log[39:32]), 32'd0);
    chk("t2_set", 32'(last_set), 32'h2);

    // Overflow: five pushes into four entries
    wb_write(A_STATUS, 32'h0000_000E);
    for (int i = 0; i < 5; i++) wb_write(A_DATA, words[i]);
    wb_read(A_STATUS, r);
    chk("t3_status", r, mstatus());
    chk("t3_status_lit", r, 32'h0000_0044);
    wb_write(A_STATUS, 32'h0000_0004);
    wb_read(A_STATUS, r);
    chk("t3_ovf_clr", r, mstatus());
    chk("t3_ovf_clr_lit", r, 32'h0000_0040);

    // Start with LEN=0, then a 64-bit run with a start written mid-run
    wb_write(A_LEN, 32'd0);
    wb_write(A_CTRL, 32'h0000_0001);
    repeat (3) @(negedge clk);
    chk("t4_len0_idle", 32'(cen), 32'd0);
    wb_read(A_STATUS, r);
    chk("t4_len_err", r, mstatus());
    chk("t4_len_err_lit", r, 32'h0000_0048);
    wb_write(A_LEN, 32'd64);
    wb_write(A_CTRL, 32'h0000_0301);
    wait_beats(10, "t4_mid");
    wb_write(A_CTRL, 32'h0000_0001);
    wait_sets(3, "t4_set_seen");
    chk("t4_beats", 32'(beats), 32'd64);
    chk("t4_set", 32'(last_set), 32'h8);
    repeat (3) @(negedge clk);
    wb_read(A_STATUS, r);
    chk("t4_status", r, mstatus());
    chk("t4_status_lit", r, 32'h0000_002A);

    // Abort after 20 beats
    s0 = sets;
    wb_write(A_CTRL, 32'h0000_0001);
    wait_beats(20, "t5_pre_abort");
    wb_write(A_CTRL, 32'h0000_0002);
    repeat (4) @(negedge clk);
    chk("t5_no_set", 32'(sets), 32'(s0));
    chk("t5_idle", 32'(cen), 32'd0);
    wb_read(A_STATUS, r);
    chk("t5_status", r, mstatus());
    chk("t5_status_lit", r, 32'h0000_0008);

    // Abort and start in one word: start is dropped
    wb_write(A_DATA, 32'h5A5A_0001);
    wb_write(A_CTRL, 32'h0000_0003);
    repeat (3) @(negedge clk);
    chk("t6_abort_wins", 32'(cen), 32'd0);
    wb_read(A_STATUS, r);
    chk("t6_status_lit", r, 32'h0000_0018);

    // Out-of-range write
    wb_miss(BASE + 32'h18, 32'hCAFE_F00D);
    wb_read(A_STATUS, r);
    chk("t7_status", r, mstatus());

    // Reset in the middle of shifting
    wb_write(A_LEN, 32'd40);
    wb_write(A_DATA, 32'h1357_9BDF);
    wb_write(A_CTRL, 32'h0000_0001);
    wait_beats(10, "t8_mid");
    rst_n = 0;
    #1;
    chk("t8_rst_outputs", 32'({ack, cen, shift, data, set}), 32'd0);
    chk("t8_rst_rdata", rdat, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    wb_read(A_STATUS, r); chk("t8_status", r, 32'd0);
    wb_read(A_LEN, r);    chk("t8_len", r, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
